med_lcd_driver: RTL
===================

MED_LCD_DRIVER -- requirements
Module: med_lcd_driver

Interface
REQ-001 SHALL have parameter T_PWRUP, default 150000: cycles waited after reset before the first LCD nibble.
REQ-002 SHALL have parameter T_EN, default 10: cycles lcd_en is held high, and cycles it is held low after each pulse.
REQ-003 SHALL have parameter T_CMD, default 500: cycles waited after every byte except Clear.
REQ-004 SHALL have parameter T_CLR, default 20000: cycles waited after the Clear (0x01) byte.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port disp_data  input  8  value to show, e.g. log time or medication ID from the log viewer.
REQ-008 SHALL have port disp_valid  input  1  one-cycle strobe qualifying disp_data.
REQ-009 SHALL have port lcd_rs  output  1  HD44780 register select: 0 command, 1 data.
REQ-010 SHALL have port lcd_en  output  1  HD44780 enable strobe.
REQ-011 SHALL have port lcd_d  output  4  HD44780 data bus D7..D4, 4-bit mode, high nibble first.
REQ-012 SHALL have port busy  output  1  high while init or an update is in progress.
REQ-013 SHALL have port init_done  output  1  high once the init sequence completes; stays high until reset.

Function
REQ-014 SHALL use FSM states PWRUP, INIT, IDLE, ADDR, CHAR, with a nibble sub-sequencer SETUP, EN_HI, EN_LO, then byte wait.
REQ-015 SHALL stay in PWRUP T_PWRUP cycles, then enter INIT.
REQ-016 SHALL in INIT send single nibbles 0x3, 0x3, 0x3, 0x2 (each followed by T_CMD wait), then bytes 0x28, 0x0C, 0x01, 0x06, all with lcd_rs=0, then enter IDLE with init_done=1.
REQ-017 SHALL transfer each nibble as: drive lcd_rs/lcd_d for 1 SETUP cycle with lcd_en=0, lcd_en=1 for T_EN cycles, lcd_en=0 for T_EN cycles; lcd_rs/lcd_d stable throughout.
REQ-018 SHALL send a byte as high nibble then low nibble, then wait T_CMD (T_CLR if byte is 0x01) before the next byte.
REQ-019 SHALL, in IDLE with disp_valid=1, capture disp_data and assert busy on the next cycle (1-cycle latency).
REQ-020 SHALL per update send ADDR byte 0x80 (rs=0), then the character bytes (rs=1) in CHAR, then return to IDLE and deassert busy.
REQ-021 SHALL by default render disp_data as three ASCII decimal digits with leading zeros, 0x30+digit, most significant first (0 -> "000", 255 -> "255").
REQ-022 SHALL hold a one-deep pending register: disp_valid while busy (including PWRUP/INIT) stores disp_data, later strobes overwrite it (latest wins).
REQ-023 SHALL, when an update finishes or init completes with a pending value, start that update directly without a cycle in IDLE with busy low.
REQ-024 SHALL, when disp_valid and an update completion occur in the same cycle, treat the new disp_data as pending and display it next.
REQ-025 SHALL not suppress repeated identical values; every accepted strobe produces one full update.
REQ-026 SHALL keep lcd_en=0 in PWRUP and IDLE.

Reset
REQ-027 SHALL on rst asynchronously force lcd_rs=0, lcd_en=0, lcd_d=0, busy=1, init_done=0, pending cleared, FSM to PWRUP.
REQ-028 SHALL on reset mid-transfer abort immediately (lcd_en drops in the same cycle) and rerun the full PWRUP and INIT sequence.
REQ-029 SHALL leave PWRUP counting from the first clock edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro LCD_HEX_DISPLAY_EN defined, render disp_data as two uppercase ASCII hex digits followed by 'h' (0xA5 -> "A5h", 0x0F -> "0Fh").
REQ-031 SHALL, without LCD_HEX_DISPLAY_EN, use decimal rendering per REQ-021 and contain no hex conversion logic.

Verification (bench parameters T_PWRUP=20, T_EN=2, T_CMD=8, T_CLR=16)
REQ-032 SHALL cover reset release: lcd_en low for 20 cycles, then nibble strobes 3,3,3,2, then bytes 28,0C,01,06 with 16-cycle gap after 01; init_done rises, busy falls.
REQ-033 SHALL cover decimal update: disp_data=0x7B with disp_valid pulse in IDLE -> busy next cycle, bytes 0x80 (rs=0), then 0x31,0x32,0x33 (rs=1), busy low after.
REQ-034 SHALL cover back-to-back strobes: 5, then 9 and 200 while busy -> display "005" then "200"; "009" never sent.
REQ-035 SHALL cover strobe during init: disp_data=42 at cycle 5 after reset -> after init, "042" sent with busy never low in between.
REQ-036 SHALL cover mid-transfer reset: rst asserted while lcd_en=1 -> lcd_en=0 the same cycle, full init replayed after release.
REQ-037 SHALL cover hex build: LCD_HEX_DISPLAY_EN defined, disp_data=0xA5 -> data bytes 0x41,0x35,0x68.

Source files
------------

// File: rtl/med_lcd_driver.sv
// HD44780 4-bit-mode LCD driver: power-up wait, init sequence, then one value shown per update.
// Rendering is three decimal digits by default; define LCD_HEX_DISPLAY_EN for two hex digits plus 'h'.
module med_lcd_driver #(
    parameter int T_PWRUP = 150000,
    parameter int T_EN    = 10,
    parameter int T_CMD   = 500,
    parameter int T_CLR   = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] disp_data,
    input  logic       disp_valid,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [3:0] lcd_d,
    output logic       busy,
    output logic       init_done
);
    localparam int MAX_A = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, CHAR} state_t;
    typedef enum logic [1:0] {SETUP, EN_HI, EN_LO, WAIT} sub_t;

    state_t        state_q, state_d;
    sub_t          sub_q, sub_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic          lo_q, lo_d;
    logic [7:0]    val_q, val_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          init_done_q, init_done_d;

    logic [7:0]    cur_byte;
    logic [7:0]    char_byte;
    logic          single_nib;
    logic          last_byte;

`ifdef LCD_HEX_DISPLAY_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        case (step_q)
            3'd0:    char_byte = hex_ascii(val_q[7:4]);
            3'd1:    char_byte = hex_ascii(val_q[3:0]);
            default: char_byte = 8'h68;
        endcase
    end
`else
    logic [7:0] dig_h, dig_t, dig_o;
    assign dig_h = val_q / 8'd100;
    assign dig_t = (val_q / 8'd10) % 8'd10;
    assign dig_o = val_q % 8'd10;

    always_comb begin
        case (step_q)
            3'd0:    char_byte = 8'h30 + dig_h;
            3'd1:    char_byte = 8'h30 + dig_t;
            default: char_byte = 8'h30 + dig_o;
        endcase
    end
`endif

    // The four wake-up nibbles are stored in the high half so the normal high-nibble path sends them.
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            INIT: begin
                case (step_q)
                    3'd0, 3'd1, 3'd2: cur_byte = 8'h30;
                    3'd3:             cur_byte = 8'h20;
                    3'd4:             cur_byte = 8'h28;
                    3'd5:             cur_byte = 8'h0C;
                    3'd6:             cur_byte = 8'h01;
                    default:          cur_byte = 8'h06;
                endcase
            end
            ADDR:    cur_byte = 8'h80;
            CHAR:    cur_byte = char_byte;
            default: cur_byte = 8'h00;
        endcase
    end

    assign single_nib = (state_q == INIT) && (step_q < 3'd4);
    assign last_byte  = (state_q == ADDR) ||
                        ((state_q == INIT) && (step_q == 3'd7)) ||
                        ((state_q == CHAR) && (step_q == 3'd2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PWRUP;
            sub_q       <= SETUP;
            cnt_q       <= CW'(T_PWRUP - 1);
            step_q      <= 3'd0;
            lo_q        <= 1'b0;
            val_q       <= 8'h00;
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            lo_q        <= lo_d;
            val_q       <= val_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        lo_d        = lo_q;
        val_d       = val_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        init_done_d = init_done_q;

        // Any strobe not taken straight from IDLE lands in the one-deep pending slot; latest wins.
        if (disp_valid && (state_q != IDLE)) begin
            pend_d      = 1'b1;
            pend_data_d = disp_data;
        end

        case (state_q)
            PWRUP: begin
                if (cnt_q == '0) begin
                    state_d = INIT;
                    sub_d   = SETUP;
                    step_d  = 3'd0;
                    lo_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            IDLE: begin
                if (disp_valid) begin
                    state_d = ADDR;
                    sub_d   = SETUP;
                    step_d  = 3'd0;
                    lo_d    = 1'b0;
                    val_d   = disp_data;
                end
            end
            default: begin
                case (sub_q)
                    SETUP: begin
                        sub_d = EN_HI;
                        cnt_d = CW'(T_EN - 1);
                    end
                    EN_HI: begin
                        if (cnt_q == '0) begin
                            sub_d = EN_LO;
                            cnt_d = CW'(T_EN - 1);
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    EN_LO: begin
                        if (cnt_q == '0) begin
                            if (!single_nib && !lo_q) begin
                                lo_d  = 1'b1;
                                sub_d = SETUP;
                            end else begin
                                sub_d = WAIT;
                                cnt_d = (cur_byte == 8'h01) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
                            end
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == '0) begin
                            lo_d  = 1'b0;
                            sub_d = SETUP;
                            if (!last_byte) begin
                                step_d = step_q + 3'd1;
                            end else if (state_q == ADDR) begin
                                state_d = CHAR;
                                step_d  = 3'd0;
                            end else begin
                                // End of init or of an update: chain straight into any waiting value.
                                if (state_q == INIT) init_done_d = 1'b1;
                                step_d = 3'd0;
                                if (disp_valid) begin
                                    state_d = ADDR;
                                    val_d   = disp_data;
                                    pend_d  = 1'b0;
                                end else if (pend_q) begin
                                    state_d = ADDR;
                                    val_d   = pend_data_q;
                                    pend_d  = 1'b0;
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        lcd_en = 1'b0;
        lcd_rs = 1'b0;
        lcd_d  = 4'h0;
        if ((state_q == INIT) || (state_q == ADDR) || (state_q == CHAR)) begin
            lcd_en = (sub_q == EN_HI);
            lcd_rs = (state_q == CHAR);
            lcd_d  = lo_q ? cur_byte[3:0] : cur_byte[7:4];
        end
    end

    assign busy      = (state_q != IDLE);
    assign init_done = init_done_q;

endmodule
